// File: rtl/axi_arb_pkg.sv
// Shared state encoding and round-robin helper for the N-to-1 bus arbiter.
package axi_arb_pkg;

   typedef enum logic [2:0] {StIdle, StAddr, StWdata, StRdata, StRerr} arb_state_t;

   // Replicated to DATA_WIDTH wherever a read-error fill pattern is returned.
   localparam logic ERR_RDATA_FILL = 1'b1;

   // Index where the round-robin search starts after master 'last' was served.
   function automatic int unsigned rr_next_idx(input int unsigned last, input int unsigned num);
      return (last + 1 >= num) ? 0 : last + 1;
   endfunction

endpackage

// File: rtl/axi_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after last_grant+1, wrapping.
module axi_rr_arbiter
   import axi_arb_pkg::*;
#(
   parameter int unsigned NUM   = 2,
   parameter int unsigned IDX_W = 1
) (
   input  logic [NUM-1:0]   req,
   input  logic [IDX_W-1:0] last_grant,
   output logic [NUM-1:0]   gnt,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   int unsigned      start;
   logic [IDX_W-1:0] cand;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      start = rr_next_idx(32'(last_grant), NUM);
      for (int unsigned k = 0; k < NUM; k++) begin
         cand = IDX_W'((start + k) % NUM);
         if (!valid && req[cand]) begin
            valid     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/axi_bus_arbiter.sv
// Round-robin N-to-1 arbiter for the simple ADDR/W/R bus; one transaction in flight at a time.
// Define AXI_ARB_TIMEOUT_EN to add the data-phase watchdog, timeout_err and the RERR state.
module axi_bus_arbiter
   import axi_arb_pkg::*;
#(
   parameter int unsigned NUM_MASTERS    = 2,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
   input  logic [NUM_MASTERS-1:0]            m_avalid,
   output logic [NUM_MASTERS-1:0]            m_aready,
   input  logic [NUM_MASTERS-1:0]            m_awrite,
   input  logic [NUM_MASTERS-1:0]            m_wvalid,
   output logic [NUM_MASTERS-1:0]            m_wready,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
   output logic [NUM_MASTERS-1:0]            m_rvalid,
   input  logic [NUM_MASTERS-1:0]            m_rready,
   output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
   output logic [ADDR_WIDTH-1:0]             s_addr,
   output logic                              s_avalid,
   input  logic                              s_aready,
   output logic                              s_awrite,
   output logic                              s_wvalid,
   input  logic                              s_wready,
   output logic [DATA_WIDTH-1:0]             s_wdata,
   input  logic                              s_rvalid,
   output logic                              s_rready,
   input  logic [DATA_WIDTH-1:0]             s_rdata,
   output logic [NUM_MASTERS-1:0]            grant,
   output logic                              busy,
   output logic                              timeout_err
);

   localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   arb_state_t             state_q;
   logic [IDX_W-1:0]       gidx_q;
   logic [IDX_W-1:0]       last_grant_q;
   logic [NUM_MASTERS-1:0] arb_gnt;
   logic [IDX_W-1:0]       arb_idx;
   logic                   arb_valid;
   logic                   wr_hs, rd_hs, wr_drop, to_idle;
   logic                   drain, drain_late;

   axi_rr_arbiter #(
      .NUM   (NUM_MASTERS),
      .IDX_W (IDX_W)
   ) u_rr (
      .req        (m_avalid),
      .last_grant (last_grant_q),
      .gnt        (arb_gnt),
      .idx        (arb_idx),
      .valid      (arb_valid)
   );

`ifdef AXI_ARB_TIMEOUT_EN
   localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q;
   logic             expire, rd_expire;

   // Counter saturates at CNT_END so an expired write keeps draining until the master offers data.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (state_q == StAddr) begin
         cnt_q <= '0;
      end else if (cnt_q != CNT_END) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign drain_late  = (state_q == StWdata) && (cnt_q == CNT_END);
   assign expire      = (cnt_q == CNT_LAST) &&
                        (((state_q == StWdata) && !wr_hs) || ((state_q == StRdata) && !rd_hs));
   assign rd_expire   = expire && (state_q == StRdata);
   assign drain       = drain_late || (expire && (state_q == StWdata));
   assign timeout_err = expire;
`else
   logic [31:0] unused_timeout_cfg;
   assign unused_timeout_cfg = TIMEOUT_CYCLES;
   assign drain_late  = 1'b0;
   assign drain       = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign wr_hs   = m_wvalid[gidx_q] && s_wready && !drain_late;
   assign rd_hs   = s_rvalid && m_rready[gidx_q];
   assign wr_drop = drain && m_wvalid[gidx_q];

   always_comb begin
      to_idle = 1'b0;
      case (state_q)
         StAddr:  to_idle = !m_avalid[gidx_q];
         StWdata: to_idle = wr_hs || wr_drop;
         StRdata: to_idle = rd_hs;
         StRerr:  to_idle = m_rready[gidx_q];
         default: to_idle = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         grant        <= '0;
         busy         <= 1'b0;
         gidx_q       <= '0;
         last_grant_q <= IDX_W'(NUM_MASTERS - 1);
      end else if (to_idle) begin
         state_q <= StIdle;
         grant   <= '0;
         busy    <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (arb_valid) begin
                  state_q <= StAddr;
                  grant   <= arb_gnt;
                  gidx_q  <= arb_idx;
                  busy    <= 1'b1;
               end
            end
            StAddr: begin
               if (s_aready) begin
                  last_grant_q <= gidx_q;
                  state_q      <= m_awrite[gidx_q] ? StWdata : StRdata;
               end
            end
`ifdef AXI_ARB_TIMEOUT_EN
            StRdata: begin
               if (rd_expire) state_q <= StRerr;
            end
`endif
            default: ;
         endcase
      end
   end

   // Slave-side fields follow the registered owner; handshakes are gated per state.
   always_comb begin
      m_aready = '0;
      m_wready = '0;
      m_rvalid = '0;
      s_avalid = 1'b0;
      s_wvalid = 1'b0;
      s_rready = 1'b0;
      s_addr   = m_addr[gidx_q*ADDR_WIDTH +: ADDR_WIDTH];
      s_awrite = m_awrite[gidx_q];
      s_wdata  = m_wdata[gidx_q*DATA_WIDTH +: DATA_WIDTH];
      m_rdata  = {NUM_MASTERS{s_rdata}};
      case (state_q)
         StAddr: begin
            s_avalid         = m_avalid[gidx_q];
            m_aready[gidx_q] = s_aready;
         end
         StWdata: begin
            if (drain) begin
               m_wready[gidx_q] = 1'b1;
            end else begin
               s_wvalid         = m_wvalid[gidx_q];
               m_wready[gidx_q] = s_wready;
            end
         end
         StRdata: begin
            m_rvalid[gidx_q] = s_rvalid;
            s_rready         = m_rready[gidx_q];
         end
`ifdef AXI_ARB_TIMEOUT_EN
         StRerr: begin
            m_rvalid[gidx_q] = 1'b1;
            m_rdata          = {(NUM_MASTERS*DATA_WIDTH){ERR_RDATA_FILL}};
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi_bus_arbiter.sv
// Directed bench for axi_bus_arbiter with three masters; covers the watchdog when AXI_ARB_TIMEOUT_EN is set.
module tb_axi_bus_arbiter;

   localparam int unsigned N  = 3;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [N*AW-1:0] m_addr;
   logic [N-1:0]  m_avalid, m_aready, m_awrite, m_wvalid, m_wready, m_rvalid, m_rready;
   logic [N*DW-1:0] m_wdata, m_rdata;
   logic [AW-1:0] s_addr;
   logic          s_avalid, s_aready, s_awrite, s_wvalid, s_wready, s_rvalid, s_rready;
   logic [DW-1:0] s_wdata, s_rdata;
   logic [N-1:0]  grant;
   logic          busy, timeout_err;

   int n_cmp = 0;
   int n_err = 0;

   logic [N-1:0] exp_order [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

   always #5 clk = ~clk;

   axi_bus_arbiter #(
      .NUM_MASTERS    (N),
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .m_addr      (m_addr),
      .m_avalid    (m_avalid),
      .m_aready    (m_aready),
      .m_awrite    (m_awrite),
      .m_wvalid    (m_wvalid),
      .m_wready    (m_wready),
      .m_wdata     (m_wdata),
      .m_rvalid    (m_rvalid),
      .m_rready    (m_rready),
      .m_rdata     (m_rdata),
      .s_addr      (s_addr),
      .s_avalid    (s_avalid),
      .s_aready    (s_aready),
      .s_awrite    (s_awrite),
      .s_wvalid    (s_wvalid),
      .s_wready    (s_wready),
      .s_wdata     (s_wdata),
      .s_rvalid    (s_rvalid),
      .s_rready    (s_rready),
      .s_rdata     (s_rdata),
      .grant       (grant),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      m_addr = '0; m_avalid = '0; m_awrite = '0; m_wvalid = '0; m_wdata = '0; m_rready = '0;
      s_aready = 1'b0; s_wready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_s_valids", 64'({s_avalid, s_wvalid, s_rready}), 64'd0);
      chk("rst_m_hs", 64'({m_aready, m_wready, m_rvalid}), 64'd0);
      chk("rst_timeout", 64'(timeout_err), 64'd0);

      // Single zero-wait write from master 0.
      m_addr[0 +: AW] = 32'h10;
      m_wdata[0 +: DW] = 32'hA5A5A5A5;
      m_avalid = 3'b001; m_awrite = 3'b001; m_wvalid = 3'b001;
      s_aready = 1'b1; s_wready = 1'b1;
      #1;
      chk("wr_idle_grant", 64'(grant), 64'd0);
      tick();
      chk("wr_addr_grant", 64'(grant), 64'b001);
      chk("wr_s_addr", 64'(s_addr), 64'h10);
      chk("wr_s_avalid", 64'(s_avalid), 64'd1);
      chk("wr_s_awrite", 64'(s_awrite), 64'd1);
      chk("wr_m_aready", 64'(m_aready), 64'b001);
      tick();
      m_avalid = '0;
      #1;
      chk("wr_s_wvalid", 64'(s_wvalid), 64'd1);
      chk("wr_s_wdata", 64'(s_wdata), 64'hA5A5A5A5);
      chk("wr_m_wready", 64'(m_wready), 64'b001);
      tick();
      m_wvalid = '0;
      #1;
      chk("wr_done_grant", 64'(grant), 64'd0);
      chk("wr_done_busy", 64'(busy), 64'd0);

      // Read from master 1 with a five-cycle slave stall.
      m_addr[AW +: AW] = 32'h04;
      m_avalid = 3'b010; m_awrite = '0; m_rready = 3'b010;
      s_rdata = 32'h1234; s_rvalid = 1'b0;
      tick();
      chk("rd_grant", 64'(grant), 64'b010);
      chk("rd_s_addr", 64'(s_addr), 64'h04);
      chk("rd_s_awrite", 64'(s_awrite), 64'd0);
      tick();
      m_avalid = '0;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("rd_stall_rvalid", 64'(m_rvalid), 64'd0);
         chk("rd_stall_busy", 64'(busy), 64'd1);
         tick();
      end
      s_rvalid = 1'b1;
      #1;
      chk("rd_m_rvalid", 64'(m_rvalid), 64'b010);
      chk("rd_m_rdata1", 64'(m_rdata[DW +: DW]), 64'h1234);
      chk("rd_m_rdata0", 64'(m_rdata[0 +: DW]), 64'h1234);
      chk("rd_s_rready", 64'(s_rready), 64'd1);
      tick();
      s_rvalid = 1'b0; m_rready = '0;
      #1;
      chk("rd_done_busy", 64'(busy), 64'd0);

      // Fairness from reset: all three masters write continuously.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_wdata = {32'h33333333, 32'h22222222, 32'h11111111};
      m_avalid = 3'b111; m_awrite = 3'b111; m_wvalid = 3'b111;
      s_aready = 1'b1; s_wready = 1'b1;
      for (int t = 0; t < 6; t++) begin
         tick();
         chk("rr_grant", 64'(grant), 64'(exp_order[t]));
         tick();
         chk("rr_s_wdata", 64'(s_wdata), 64'(32'h11111111 * (t % 3 + 1)));
         tick();
         chk("rr_idle_busy", 64'(busy), 64'd0);
      end
      m_avalid = '0; m_wvalid = '0; m_awrite = '0;

      // Master 0 drops avalid before the slave accepts; last_grant (2) must be kept.
      m_addr[0 +: AW] = 32'h20;
      m_avalid = 3'b001; s_aready = 1'b0;
      tick();
      chk("viol_grant", 64'(grant), 64'b001);
      chk("viol_s_avalid", 64'(s_avalid), 64'd1);
      m_avalid = '0;
      #1;
      chk("viol_drop_s_avalid", 64'(s_avalid), 64'd0);
      tick();
      chk("viol_idle_busy", 64'(busy), 64'd0);
      chk("viol_idle_grant", 64'(grant), 64'd0);
      m_avalid = 3'b011; m_awrite = '0; m_rready = '0; s_aready = 1'b1;
      tick();
      chk("viol_next_grant", 64'(grant), 64'b001);

      // Reset while a read response is pending; last_grant must return to NUM_MASTERS-1.
      tick();
      m_avalid = '0; s_rvalid = 1'b1; s_rdata = 32'hDEAD;
      #1;
      chk("rstmid_rvalid", 64'(m_rvalid), 64'b001);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rstmid_busy", 64'(busy), 64'd0);
      chk("rstmid_grant", 64'(grant), 64'd0);
      chk("rstmid_s_rready", 64'(s_rready), 64'd0);
      chk("rstmid_m_rvalid", 64'(m_rvalid), 64'd0);
      s_rvalid = 1'b0;
      m_avalid = 3'b011; m_awrite = 3'b011; m_wvalid = 3'b011;
      tick();
      chk("rstmid_next_grant", 64'(grant), 64'b001);
      tick();
      m_avalid = '0;
      #1;
      chk("rstmid_s_wdata", 64'(s_wdata), 64'h11111111);
      tick();
      m_wvalid = '0; m_awrite = '0;

      // Master 2 reads from a slave that never answers.
      m_addr[2*AW +: AW] = 32'h08;
      m_avalid = 3'b100; m_rready = 3'b100; s_aready = 1'b1; s_rvalid = 1'b0;
      tick();
      chk("to_grant", 64'(grant), 64'b100);
      tick();
      m_avalid = '0;
      #1;
`ifdef AXI_ARB_TIMEOUT_EN
      for (int c = 1; c < 8; c++) begin
         chk("to_early", 64'(timeout_err), 64'd0);
         tick();
      end
      chk("to_pulse", 64'(timeout_err), 64'd1);
      tick();
      chk("to_pulse_end", 64'(timeout_err), 64'd0);
      chk("to_err_rvalid", 64'(m_rvalid), 64'b100);
      chk("to_err_rdata", 64'(m_rdata[2*DW +: DW]), 64'hFFFFFFFF);
      chk("to_err_s_rready", 64'(s_rready), 64'd0);
      tick();
      chk("to_done_busy", 64'(busy), 64'd0);
      chk("to_done_rvalid", 64'(m_rvalid), 64'd0);
      m_rready = '0;
`else
      for (int c = 1; c <= 12; c++) begin
         chk("hang_timeout", 64'(timeout_err), 64'd0);
         chk("hang_busy", 64'(busy), 64'd1);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_rready = '0;
      #1;
      chk("hang_rst_busy", 64'(busy), 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
